// File: rtl/mult_pkg.sv
// Shared types for the sequential shift-and-add multiplier.
package mult_pkg;

    localparam int MULT_WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

endpackage

// File: rtl/somador_param.sv
// Parametrised W-bit adder/subtractor; carry-out is dropped (modulo 2^W).
module somador_param #(
    parameter int W = 16
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         sub,
    output logic [W-1:0] s
);

    assign s = sub ? (a - b) : (a + b);

endmodule

// File: rtl/multiplicador_seq_n.sv
// Sequential N-bit multiplier, one multiplier bit per cycle, unsigned or two's-complement.
// Optional early termination for unsigned operands: MULT_EARLY_EXIT_EN.
//
// state | meaning
// IDLE  | waiting for Start; S holds the last product
// RUN   | one partial product per cycle accumulated into S
// DONE  | product complete; returns to IDLE next edge
module multiplicador_seq_n
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH_DEF,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic               Start,
    input  logic               Sgn,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    output logic [2*WIDTH-1:0] S,
    output logic               Busy,
    output logic               Done
);

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]   b_reg;
    logic               sgn_reg;

    logic [2*WIDTH-1:0] a_ext;
    logic [2*WIDTH-1:0] addend;
    logic [2*WIDTH-1:0] sum;
    logic               sub;
    logic               last_step;

    assign a_ext  = sgn_reg ? {{WIDTH{a_reg[WIDTH-1]}}, a_reg} : {{WIDTH{1'b0}}, a_reg};
    assign addend = b_reg[cnt] ? (a_ext << cnt) : '0;
    // The sign bit of a two's-complement multiplier carries negative weight.
    assign sub    = sgn_reg && (cnt == CNT_W'(WIDTH - 1));

`ifdef MULT_EARLY_EXIT_EN
    logic [WIDTH-1:0] b_rem;
    assign b_rem     = b_reg >> cnt;
    assign last_step = (cnt == CNT_W'(WIDTH - 1)) || (!sgn_reg && (b_rem[WIDTH-1:1] == '0));
`else
    assign last_step = (cnt == CNT_W'(WIDTH - 1));
`endif

    somador_param #(
        .W (2*WIDTH)
    ) u_somador (
        .a   (S),
        .b   (addend),
        .sub (sub),
        .s   (sum)
    );

    // Busy/Done are registered from the current state, so they trail it by one edge.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state   <= IDLE;
            cnt     <= '0;
            a_reg   <= '0;
            b_reg   <= '0;
            sgn_reg <= 1'b0;
            S       <= '0;
            Busy    <= 1'b0;
            Done    <= 1'b0;
        end else begin
            Busy <= (state == RUN);
            Done <= (state == DONE);
            case (state)
                IDLE: begin
                    if (Start) begin
                        a_reg   <= A;
                        b_reg   <= B;
                        sgn_reg <= Sgn;
                        S       <= '0;
                        cnt     <= '0;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    S <= sum;
                    if (last_step) begin
                        state <= DONE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multiplicador_seq_n.sv
// Directed-vector bench for multiplicador_seq_n (WIDTH=8 and WIDTH=16 instances).
module tb_multiplicador_seq_n;

    logic        Clk;
    logic        Rst;
    logic        Start;
    logic        Sgn;
    logic [7:0]  A;
    logic [7:0]  B;
    logic [15:0] S;
    logic        Busy;
    logic        Done;

    logic        start16;
    logic [15:0] a16;
    logic [15:0] b16;
    logic [31:0] s16;
    logic        busy16;
    logic        done16;

    int n_vec = 0;
    int n_err = 0;

    multiplicador_seq_n #(.WIDTH(8)) dut (
        .Clk   (Clk),
        .Rst   (Rst),
        .Start (Start),
        .Sgn   (Sgn),
        .A     (A),
        .B     (B),
        .S     (S),
        .Busy  (Busy),
        .Done  (Done)
    );

    multiplicador_seq_n #(.WIDTH(16)) dut16 (
        .Clk   (Clk),
        .Rst   (Rst),
        .Start (start16),
        .Sgn   (1'b0),
        .A     (a16),
        .B     (b16),
        .S     (s16),
        .Busy  (busy16),
        .Done  (done16)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Number of RUN cycles expected for an 8-bit operation.
    function automatic int run_len(input logic sgn, input logic [7:0] b);
        int r;
        r = 1;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) r = i + 1;
        end
        if (sgn) r = 8;
`ifndef MULT_EARLY_EXIT_EN
        r = 8;
`endif
        return r;
    endfunction

    task automatic do_op(input string tag, input logic sgn, input logic [7:0] a,
                         input logic [7:0] b, input logic [15:0] exp);
        int n;
        int nb;
        @(negedge Clk);
        Sgn   = sgn;
        A     = a;
        B     = b;
        Start = 1'b1;
        @(posedge Clk);
        #1;
        Start = 1'b0;
        A     = ~a;
        B     = ~b;
        Sgn   = ~sgn;
        n  = 0;
        nb = 0;
        while (Done !== 1'b1 && n < 40) begin
            @(posedge Clk);
            #1;
            n++;
            if (Busy === 1'b1) nb++;
        end
        chk({tag, ".latency"}, 64'(n), 64'(run_len(sgn, b) + 1));
        chk({tag, ".busy_cycles"}, 64'(nb), 64'(run_len(sgn, b)));
        chk({tag, ".product"}, 64'(S), 64'(exp));
        @(posedge Clk);
        #1;
        chk({tag, ".done_pulse"}, 64'(Done), 64'd0);
        chk({tag, ".hold"}, 64'(S), 64'(exp));
    endtask

    initial begin
        int d_cnt;
        int d1;
        int d2;
        int n;
        logic [15:0] s1;
        logic [15:0] s2;

        Rst     = 1'b0;
        Start   = 1'b0;
        Sgn     = 1'b0;
        A       = '0;
        B       = '0;
        start16 = 1'b0;
        a16     = '0;
        b16     = '0;
        repeat (2) @(posedge Clk);
        #1;
        chk("reset.S", 64'(S), 64'd0);
        chk("reset.Busy", 64'(Busy), 64'd0);
        chk("reset.Done", 64'(Done), 64'd0);
        chk("reset16.S", 64'(s16), 64'd0);
        Rst = 1'b1;

        do_op("u_ff_ff",   1'b0, 8'd255, 8'd255, 16'hFE01);
        do_op("u_200_3",   1'b0, 8'd200, 8'd3,   16'd600);
        do_op("u_200_0",   1'b0, 8'd200, 8'd0,   16'd0);
        do_op("u_13_11",   1'b0, 8'd13,  8'd11,  16'd143);
        do_op("s_m128sq",  1'b1, 8'h80,  8'h80,  16'h4000);
        do_op("s_m1_127",  1'b1, 8'hFF,  8'h7F,  16'hFF81);
        do_op("s_5_m3",    1'b1, 8'd5,   8'hFD,  16'hFFF1);
        do_op("s_127_m128",1'b1, 8'h7F,  8'h80,  16'hC080);
        do_op("s_m1_m1",   1'b1, 8'hFF,  8'hFF,  16'h0001);

        // Start held high, operands changed mid-operation.
        @(negedge Clk);
        Sgn   = 1'b0;
        A     = 8'd10;
        B     = 8'd20;
        Start = 1'b1;
        @(posedge Clk);
        #1;
        A     = 8'd3;
        B     = 8'd7;
        d_cnt = 0;
        d1    = 0;
        d2    = 0;
        s1    = '0;
        s2    = '0;
        for (int e = 1; e <= 30; e++) begin
            @(posedge Clk);
            #1;
            if (Done === 1'b1) begin
                d_cnt++;
                if (d_cnt == 1) begin
                    d1 = e;
                    s1 = S;
                end else if (d_cnt == 2) begin
                    d2 = e;
                    s2 = S;
                    Start = 1'b0;
                end
            end
        end
        Start = 1'b0;
        chk("held.done_count", 64'(d_cnt), 64'd2);
        chk("held.first_edge", 64'(d1), 64'(run_len(1'b0, 8'd20) + 1));
        chk("held.first_S", 64'(s1), 64'd200);
        chk("held.second_edge", 64'(d2), 64'(run_len(1'b0, 8'd20) + run_len(1'b0, 8'd7) + 3));
        chk("held.second_S", 64'(s2), 64'd21);

        // Reset at the 4th RUN edge, with Start asserted on the same edge.
        @(negedge Clk);
        Sgn   = 1'b0;
        A     = 8'd7;
        B     = 8'd9;
        Start = 1'b1;
        @(posedge Clk);
        #1;
        Start = 1'b0;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        Rst   = 1'b0;
        Start = 1'b1;
        A     = 8'd5;
        B     = 8'd5;
        @(posedge Clk);
        #1;
        chk("midreset.S", 64'(S), 64'd0);
        chk("midreset.Busy", 64'(Busy), 64'd0);
        chk("midreset.Done", 64'(Done), 64'd0);
        Rst   = 1'b1;
        Start = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        chk("midreset.start_ignored", 64'(Busy), 64'd0);
        do_op("after_reset", 1'b0, 8'd3, 8'd4, 16'd12);

        // 16-bit instance.
        @(negedge Clk);
        a16     = 16'hFFFF;
        b16     = 16'hFFFF;
        start16 = 1'b1;
        @(posedge Clk);
        #1;
        start16 = 1'b0;
        n = 0;
        while (done16 !== 1'b1 && n < 60) begin
            @(posedge Clk);
            #1;
            n++;
        end
        chk("w16.latency", 64'(n), 64'd17);
        chk("w16.product", 64'(s16), 64'hFFFE0001);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
